// File: rtl/store_pkg.sv
// -----------------------------------------------------------------------------
// store_pkg
// Shared definitions for the store narrowing path.
//   - SZ_*     : request size encodings carried on req_size
//   - state_t  : store sequencer states (IDLE / BEAT0 / BEAT1)
//   - MASK_*   : base byte-enable masks before lane shifting
// No ports; imported by store_lane_shifter and store_narrower.
// -----------------------------------------------------------------------------
package store_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;
    localparam logic [3:0] MASK_NONE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

endpackage

// File: rtl/store_lane_shifter.sv
// -----------------------------------------------------------------------------
// store_lane_shifter
// Purely combinational lane placement for a store of 1/2/4 bytes at a byte
// offset within a word. The 8-bit enable and 64-bit data outputs span two
// consecutive words so a word-crossing access can be split into two beats.
// Ports:
//   size [1:0]  in  : SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD (reserved -> nothing)
//   off  [1:0]  in  : byte offset within the first word
//   data [31:0] in  : register value; bytes above the size are forced to zero
//   m8   [7:0]  out : byte enables over two words (low nibble = first word)
//   d64  [63:0] out : lane-positioned data over two words
// -----------------------------------------------------------------------------
module store_lane_shifter
    import store_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    output logic [7:0]  m8,
    output logic [63:0] d64
);

    logic [3:0]  mask4;
    logic [31:0] data_m;

    always_comb begin
        mask4 = MASK_NONE;
        case (size)
            SZ_BYTE: mask4 = MASK_BYTE;
            SZ_HALF: mask4 = MASK_HALF;
            SZ_WORD: mask4 = MASK_WORD;
            SZ_RSVD: mask4 = MASK_NONE;
            default: mask4 = MASK_NONE;
        endcase
    end

    // The enable mask doubles as the data qualifier, so unused lanes are zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_mask
            assign data_m[8*gi +: 8] = data[8*gi +: 8] & {8{mask4[gi]}};
        end
    endgenerate

    assign m8  = {4'b0000, mask4} << off;
    assign d64 = {32'b0, data_m} << {off, 3'b000};

endmodule

// File: rtl/store_narrower.sv
// -----------------------------------------------------------------------------
// store_narrower
// Narrows a 32-bit register value to byte/half/word and issues one or two
// word-aligned write beats to data memory. A store whose bytes cross a word
// boundary is split into BEAT0 (low word) and BEAT1 (next word, address
// wrapping modulo 2^ADDR_W). All memory-side outputs are registered.
//
// Build option: STORE_MISALIGN_TRAP_EN
//   defined   -> misaligned half/word stores are rejected with an err pulse
//                and no beats; BEAT1 becomes unreachable.
//   undefined -> misaligned stores are split; err only for reserved size.
//
// Ports:
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   : store request handshake (ready only in IDLE)
//   req_addr [ADDR_W-1:0] : byte address
//   req_data [31:0]       : register value
//   req_size [1:0]        : 00 byte, 01 half, 10 word, 11 reserved
//   mem_valid/mem_ready   : write beat handshake
//   mem_addr [ADDR_W-1:0] : word-aligned beat address
//   mem_wdata [31:0]      : lane-positioned write data, disabled lanes zero
//   mem_be [3:0]          : byte enables, bit i = lane i
//   err                   : one-cycle pulse for a rejected request
//   busy                  : high whenever not IDLE
// -----------------------------------------------------------------------------
module store_narrower
    import store_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              err,
    output logic              busy
);

    state_t            state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [3:0]        hi_be_q, hi_be_d;
    logic [31:0]       hi_data_q, hi_data_d;
    logic              err_q, err_d;

    logic [7:0]        m8;
    logic [63:0]       d64;
    logic              misalign;
    logic              reject;

    store_lane_shifter u_shifter (
        .size (req_size),
        .off  (req_addr[1:0]),
        .data (req_data),
        .m8   (m8),
        .d64  (d64)
    );

`ifdef STORE_MISALIGN_TRAP_EN
    assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign reject = (req_size == SZ_RSVD) || misalign;

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        hi_be_d     = hi_be_q;
        hi_data_d   = hi_data_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = BEAT0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = m8[3:0];
                        mem_wdata_d = d64[31:0];
                        // Upper word is parked until BEAT0 completes.
                        hi_be_d     = m8[7:4];
                        hi_data_d   = d64[63:32];
                    end
                end
            end
            BEAT0: begin
                if (mem_ready) begin
                    if (hi_be_q != 4'b0000) begin
                        // Back-to-back second beat, no bubble on mem_valid.
                        state_d     = BEAT1;
                        mem_addr_d  = mem_addr_q + ADDR_W'(4);
                        mem_be_d    = hi_be_q;
                        mem_wdata_d = hi_data_q;
                    end else begin
                        state_d     = IDLE;
                        mem_valid_d = 1'b0;
                        mem_addr_d  = '0;
                        mem_be_d    = 4'b0000;
                        mem_wdata_d = 32'b0;
                    end
                end
            end
            BEAT1: begin
                if (mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = 4'b0000;
                    mem_wdata_d = 32'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'b0;
            mem_be_q    <= 4'b0000;
            hi_be_q     <= 4'b0000;
            hi_data_q   <= 32'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            hi_be_q     <= hi_be_d;
            hi_data_q   <= hi_data_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_narrower.sv
// -----------------------------------------------------------------------------
// tb_store_narrower
// Self-checking bench for store_narrower. A byte-by-byte reference model
// predicts the beats of each store and pushes them onto a scoreboard queue;
// a negedge monitor pops and compares every accepted beat and checks that
// stalled beats hold stable. Honours STORE_MISALIGN_TRAP_EN in the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_store_narrower;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        err;
    logic        busy;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    beat_t sb[$];
    int    total = 0;
    int    bad = 0;
    logic  rand_ready = 1'b0;

    logic        stall_q = 1'b0;
    logic [31:0] h_addr = 32'h0;
    logic [31:0] h_wdata = 32'h0;
    logic [3:0]  h_be = 4'h0;

    store_narrower #(.ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Random memory back-pressure, changed away from the sampling edge.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1 mem_ready = 1'($urandom_range(0, 1));
        end
    end

    // Beat monitor: pops the scoreboard on each handshake, checks hold on stall.
    always @(negedge clk) begin
        if (reset) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 64'(mem_valid), 64'd1);
                chk("hold_addr",  64'(mem_addr),  64'(h_addr));
                chk("hold_be",    64'(mem_be),    64'(h_be));
                chk("hold_wdata", 64'(mem_wdata), 64'(h_wdata));
            end
            if (mem_valid && mem_ready) begin
                $display("beat addr=%08h be=%04b wdata=%08h", mem_addr, mem_be, mem_wdata);
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("beat_addr",  64'(mem_addr),  64'(e.addr));
                    chk("beat_be",    64'(mem_be),    64'(e.be));
                    chk("beat_wdata", 64'(mem_wdata), 64'(e.wdata));
                end
            end
            stall_q <= mem_valid && !mem_ready;
            h_addr  <= mem_addr;
            h_be    <= mem_be;
            h_wdata <= mem_wdata;
        end
    end

    // Drive one request, predict its beats, and check err/mem_valid in N+1.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        beat_t b0;
        beat_t b1;
        int    nbytes;
        int    n;
        int    lane;
        logic  exp_err;
        logic [2:0] pos;
        nbytes  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        exp_err = (sz == 2'd3);
`ifdef STORE_MISALIGN_TRAP_EN
        if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)) exp_err = 1'b1;
`endif
        b0 = '0;
        b1 = '0;
        b0.addr = {a[31:2], 2'b00};
        b1.addr = b0.addr + 32'd4;
        for (int i = 0; i < nbytes; i++) begin
            pos  = {1'b0, a[1:0]} + 3'(i);
            lane = int'(pos[1:0]);
            if (pos < 3'd4) begin
                b0.be[lane] = 1'b1;
                b0.wdata[8*lane +: 8] = d[8*i +: 8];
            end else begin
                b1.be[lane] = 1'b1;
                b1.wdata[8*lane +: 8] = d[8*i +: 8];
            end
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 100);
        if (!req_ready) chk("req_ready_wait", 64'd0, 64'd1);
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        req_valid = 1'b1;
        if (!exp_err) begin
            sb.push_back(b0);
            if (b1.be != 4'b0000) sb.push_back(b1);
        end
        $display("req addr=%08h data=%08h size=%0d exp_err=%0d", a, d, sz, exp_err);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("err_n1",   64'(err),       64'(exp_err));
        chk("valid_n1", 64'(mem_valid), 64'(!exp_err));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(req_ready && sb.size() == 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(req_ready && sb.size() == 0)) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_mem_addr",  64'(mem_addr),  64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_mem_be",    64'(mem_be),    64'd0);
        chk("rst_err",       64'(err),       64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        mem_ready = 1'b1;

        // Aligned word: single beat, req_ready back two cycles after accept.
        send(32'h0000_1000, 32'hDEAD_BEEF, 2'b10);
        chk("w_busy", 64'(busy), 64'd1);
        chk("w_ready_low", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("w_ready_back", 64'(req_ready), 64'd1);
        chk("w_valid_drop", 64'(mem_valid), 64'd0);
        wait_idle();

        // Byte at top lane, upper data bytes ignored.
        send(32'h0000_1003, 32'h1234_56AB, 2'b00);
        wait_idle();

        // Word crossing a boundary (or trapped when alignment is enforced).
        send(32'h0000_1002, 32'h1122_3344, 2'b10);
        wait_idle();

        // Half crossing the top of the address space.
        send(32'hFFFF_FFFF, 32'hA5A5_BEEF, 2'b01);
        wait_idle();

        // Half with back-pressure: beat held for 4 cycles, one handshake.
        @(posedge clk);
        #1 mem_ready = 1'b0;
        send(32'h0000_2002, 32'h0000_5A5A, 2'b01);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_valid", 64'(mem_valid), 64'd1);
            chk("stall_addr",  64'(mem_addr),  64'h2000);
            chk("stall_be",    64'(mem_be),    64'hC);
            chk("stall_wdata", 64'(mem_wdata), 64'h5A5A_0000);
            chk("stall_ready", 64'(req_ready), 64'd0);
            if (k == 2) begin
                @(posedge clk);
                #1 mem_ready = 1'b1;
            end
        end
        @(negedge clk);
        chk("stall_done_valid", 64'(mem_valid), 64'd0);
        chk("stall_done_ready", 64'(req_ready), 64'd1);
        chk("stall_sb_empty",   64'(sb.size()), 64'd0);

        // Reserved size: err for exactly one cycle, no traffic.
        send(32'h0000_4000, 32'h1234_5678, 2'b11);
        @(negedge clk);
        chk("rsvd_err_gone", 64'(err),       64'd0);
        chk("rsvd_no_valid", 64'(mem_valid), 64'd0);
        chk("rsvd_ready",    64'(req_ready), 64'd1);

        // Reset while a beat is pending.
`ifdef STORE_MISALIGN_TRAP_EN
        @(posedge clk);
        #1 mem_ready = 1'b0;
        send(32'h0000_3000, 32'hCAFE_F00D, 2'b10);
        chk("pre_rst_addr", 64'(mem_addr), 64'h3000);
`else
        send(32'h0000_3001, 32'hCAFE_F00D, 2'b10);
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_addr", 64'(mem_addr), 64'h3004);
        chk("pre_rst_be",   64'(mem_be),   64'h1);
`endif
        chk("pre_rst_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 64'(mem_valid), 64'd0);
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        chk("post_rst_busy",  64'(busy),      64'd0);
        sb.delete();

        // Random stores under random back-pressure.
        rand_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            send($urandom, $urandom, 2'($urandom_range(0, 3)));
        end
        wait_idle();
        @(negedge clk);
        rand_ready = 1'b0;
        @(posedge clk);
        #1 mem_ready = 1'b1;
        @(negedge clk);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        chk("final_idle",     64'(busy),      64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
